imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Upstream of the pipelined core. Receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the core in reset until the whole image is loaded, then releases it so fetch starts at BASE_ADDR.

Parameters:
- MAX_WORDS, 64, maximum instruction words accepted; legal header counts are 1..MAX_WORDS.
- BASE_ADDR, 64'd0, byte address of the first word written; matches the core's PC reset value.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- byte_valid  input  1  source presents byte_data
- byte_data  input  8  stream byte
- byte_ready  output  1  loader can accept a byte this cycle
- im_we  output  1  instruction memory write strobe, one cycle per word
- im_addr  output  64  byte address of the word being written
- im_wdata  output  32  instruction word
- cpu_reset  output  1  active-high hold for the core (PC, register file); 1 until load completes
- done  output  1  image fully written; sticky
- error  output  1  illegal header count; sticky
- words_loaded  output  16  number of words written so far

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=HDR_LO, byte_ready=1, cpu_reset=1, done=0, error=0.
  - im_we=0, im_addr=0, im_wdata=0, words_loaded=0, byte index=0.
  - Memory contents are not touched.
- Byte accepted: byte_valid && byte_ready at a rising edge. When byte_ready=0, byte_valid is ignored and the byte is not consumed; the source holds it.
- Stream format: 2-byte little-endian word count, then count*4 bytes, each word least-significant byte first.
- All outputs are registered. State machine:
  - HDR_LO: accept byte -> count[7:0], go to HDR_HI.
  - HDR_HI: accept byte -> count[15:8].
    - If the full 16-bit count ==0 or >MAX_WORDS, go to ERROR.
    - Otherwise go to DATA with byte index=0.
  - DATA: byte_ready=1. Each accepted byte goes to im_wdata[8*idx+7:8*idx] and idx increments (mod 4). When the 4th byte is accepted, go to WRITE.
  - WRITE: lasts exactly one cycle.
    - byte_ready=0, im_we=1.
    - im_addr = BASE_ADDR + 4*words_loaded (64-bit, no wrap check needed within MAX_WORDS).
    - im_wdata holds the assembled word.
    - At the next edge: im_we=0, words_loaded+1. Go to DONE if the new words_loaded==count, else DATA.
  - DONE: byte_ready=0, done=1, cpu_reset=0. Both become visible the edge after the final write edge. Held until reset.
  - ERROR: byte_ready=0, error=1, cpu_reset=1, im_we never asserted. Held until reset.
- Latency and throughput:
  - im_we rises the edge after the 4th byte of a word is accepted.
  - Minimum 5 cycles per word with byte_valid held high.
- im_addr and im_wdata remain stable outside WRITE (last values); consumers qualify them with im_we only.
- Reset mid-load: returns immediately to the reset state. Partially written memory is left as is. A fresh header restarts writes at BASE_ADDR.
- Simultaneous events: reset low overrides any handshake in the same cycle. A byte offered during WRITE, DONE or ERROR is never consumed.
- words_loaded never exceeds count; error and done are never both 1.

Test Plan:
- Header 02 00, then bytes 13 05 A0 00 93 05 B0 00, byte_valid held high:
  - im_we pulses twice: (addr 0, data 0x00A00513) and (addr 4, data 0x00B00593).
  - words_loaded=2; done=1 and cpu_reset=0 one edge after the second write; no other writes.
- Same image with byte_valid toggled pseudo-randomly and a byte presented during each WRITE cycle -> identical write sequence; the held byte is consumed only after WRITE.
- Header 00 00 -> error=1, cpu_reset stays 1, byte_ready=0, im_we never asserts, following bytes ignored.
- Header 41 00 (65 > MAX_WORDS) -> error=1.
  - Separately, header 40 00 plus 256 bytes -> 64 writes, last im_addr=252, done=1.
- Header 03 00 plus 5 data bytes, then reset low for one cycle:
  - All outputs return to reset values.
  - A new load with header 01 00 and 4 bytes writes addr 0, and done follows.
- After done: 10 more valid bytes -> byte_ready=0, no im_we, words_loaded unchanged, done and cpu_reset=0 held.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a program image as a byte stream, assembles
// little-endian 32-bit words and writes them to instruction memory. The core
// is held in reset until the whole image has been written.
//
// state    | meaning
// ---------+------------------------------------------------------------
// HDR_LO   | waiting for word-count low byte
// HDR_HI   | waiting for word-count high byte; range check on the count
// DATA     | collecting the four bytes of the next word, LSB first
// WRITE    | single-cycle write strobe to instruction memory
// DONE     | image complete, core released; held until reset
// ERROR    | illegal word count, core kept in reset; held until reset
module imem_boot_loader #(
    parameter int          MAX_WORDS = 64,
    parameter logic [63:0] BASE_ADDR = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        im_we,
    output logic [63:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam logic [15:0] MAX_WORDS_W = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] asm_q, asm_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] words_q, words_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        cpu_rst_q, cpu_rst_d;

    logic        accept;
    logic [15:0] hdr_count;

    assign accept    = byte_valid && ready_q;
    assign hdr_count = {byte_data, count_q[7:0]};

    // Next-state and registered-output computation. Bytes are assembled in a
    // private register so im_wdata only changes when a write is issued.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        words_d   = words_q;

        case (state_q)
            S_HDR_LO: begin
                if (accept) begin
                    count_d[7:0] = byte_data;
                    state_d      = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (accept) begin
                    count_d = hdr_count;
                    if (hdr_count == 16'd0 || hdr_count > MAX_WORDS_W) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = 2'd0;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d[8*idx_q +: 8] = byte_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        addr_d  = BASE_ADDR + {46'd0, words_q, 2'b00};
                        wdata_d = {byte_data, asm_q[23:0]};
                    end
                end
            end
            S_WRITE: begin
                words_d = words_q + 16'd1;
                state_d = (words_q + 16'd1 == count_q) ? S_DONE : S_DATA;
            end
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_HDR_LO;
        endcase

        ready_d   = (state_d == S_HDR_LO) || (state_d == S_HDR_HI) || (state_d == S_DATA);
        done_d    = (state_d == S_DONE);
        error_d   = (state_d == S_ERROR);
        cpu_rst_d = (state_d != S_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_HDR_LO;
            count_q   <= 16'd0;
            idx_q     <= 2'd0;
            asm_q     <= 32'd0;
            we_q      <= 1'b0;
            addr_q    <= 64'd0;
            wdata_q   <= 32'd0;
            words_q   <= 16'd0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            asm_q     <= asm_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            words_q   <= words_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign byte_ready   = ready_q;
    assign im_we        = we_q;
    assign im_addr      = addr_q;
    assign im_wdata     = wdata_q;
    assign cpu_reset    = cpu_rst_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule
